// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared SAP-1 types and default widths
package sap1_pkg;

   localparam int SAP1_ADDR_W = 4;

   typedef enum logic [0:0] {
      PC_RUN  = 1'b0,
      PC_HALT = 1'b1
   } pc_state_t;

endpackage

// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - LIFO return-address stack with async-cleared pointer
module pc_return_stack
   import sap1_pkg::*;
#(
   parameter int W     = SAP1_ADDR_W,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          CLR,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  push_data,
   output logic [W-1:0]  data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Storage is never reset; only the pointer is, so stale entries are never read.
   logic [W-1:0]  mem [2**AW];
   logic [CW-1:0] ptr;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic [CW-1:0] ptr_dec;

   assign ptr_dec = ptr - CW'(1);
   assign wr_idx  = AW'(ptr);
   assign rd_idx  = AW'(ptr_dec);
   assign full    = (ptr == CW'(DEPTH));
   assign empty   = (ptr == '0);
   assign count   = ptr;
   assign data    = mem[rd_idx];

   always_ff @(posedge CLK) begin
      if (push && !full) begin
         mem[wr_idx] <= push_data;
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         ptr <= '0;
      end else if (push && !full) begin
         ptr <= ptr + CW'(1);
      end else if (pop && !empty) begin
         ptr <= ptr_dec;
      end
   end

endmodule

// File: rtl/program_counter_stack.sv
// rtl/program_counter_stack.sv - SAP-1 program counter with jump, call/return stack and halt
module program_counter_stack
   import sap1_pkg::*;
#(
   parameter int ADDR_W      = SAP1_ADDR_W,
   parameter int STACK_DEPTH = 4,
   localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
   input  logic               CLK,
   input  logic               CLR,
   input  logic               Cp,
   input  logic               Ep,
   input  logic               Ej,
   input  logic               JCond,
   input  logic               Call,
   input  logic               Ret,
   input  logic               Hlt,
   input  logic [ADDR_W-1:0]  Addr,
   output logic [ADDR_W-1:0]  Out,
   output logic               Halted,
   output logic               Ovf,
   output logic               Unf,
   output logic [DEPTH_W-1:0] Depth
);

   pc_state_t         state;
   pc_state_t         state_next;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] stack_top;
   logic              push;
   logic              pop;
   logic              set_ovf;
   logic              set_unf;
   logic              stack_full;
   logic              stack_empty;
   logic              ovf;
   logic              unf;

   assign pc_inc = pc + ADDR_W'(1);

   pc_return_stack #(
      .W     (ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .CLK       (CLK),
      .CLR       (CLR),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .data      (stack_top),
      .full      (stack_full),
      .empty     (stack_empty),
      .count     (Depth)
   );

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state <= PC_RUN;
      end else begin
         state <= state_next;
      end
   end

   // One action per edge; a Ret silently swallows a simultaneous Call.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      push       = 1'b0;
      pop        = 1'b0;
      set_ovf    = 1'b0;
      set_unf    = 1'b0;
      case (state)
         PC_RUN: begin
            if (Hlt) begin
               state_next = PC_HALT;
            end else if (Ret) begin
               if (!stack_empty) begin
                  pop     = 1'b1;
                  pc_next = stack_top;
               end else begin
                  set_unf = 1'b1;
               end
            end else if (Call) begin
               if (!stack_full) begin
                  push    = 1'b1;
                  pc_next = Addr;
               end else begin
                  set_ovf = 1'b1;
               end
            end else if (Ej && JCond) begin
               pc_next = Addr;
            end else if (Cp) begin
               pc_next = pc_inc;
            end
         end
         default: begin
            state_next = state;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         pc  <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         pc  <= pc_next;
         ovf <= ovf | set_ovf;
         unf <= unf | set_unf;
      end
   end

   assign Out    = Ep ? pc : '0;
   assign Halted = (state == PC_HALT);
   assign Ovf    = ovf;
   assign Unf    = unf;

endmodule
